// File: rtl/hardcopyii_deser14_if.sv
// hardcopyii_deser14_if: serial beat input and assembled word output of the 1-to-4 deserializer
//   in_data/in_valid/in_ready : serial beat handshake (master -> deserializer)
//   align                     : realign request, next accepted beat becomes lane 0
//   out_data/out_valid/out_ready : assembled 4*WIDTH word handshake (deserializer -> consumer)
//   lane_sel                  : lane the next accepted beat fills
interface hardcopyii_deser14_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic               align;
  logic [4*WIDTH-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         lane_sel;
  modport master (output in_data, in_valid, align, out_ready, input in_ready, out_data, out_valid, lane_sel);
  modport slave (input in_data, in_valid, align, out_ready, output in_ready, out_data, out_valid, lane_sel);
endinterface

// File: rtl/hardcopyii_deser14.sv
// hardcopyii_deser14: registered 1-to-4 deserializer with valid/ready on both sides
//   clk  : rising-edge clock
//   aclr : asynchronous active-high reset
//   bus  : slave side of hardcopyii_deser14_if (serial beats in, 4*WIDTH words out)
module hardcopyii_deser14 #(parameter int WIDTH = 1) (
  input logic clk,
  input logic aclr,
  hardcopyii_deser14_if.slave bus
);
  logic [1:0]            sel_q, sel_d;
  logic [2:0][WIDTH-1:0] lane_q, lane_d;
  logic [4*WIDTH-1:0]    out_q, out_d;
  logic                  ov_q, ov_d;
  logic                  acc, done;
  // only the completing beat stalls, and only when the held word is not leaving this cycle
  assign bus.in_ready = !aclr && !bus.align && !(sel_q == 2'd3 && ov_q && !bus.out_ready);
  assign acc = bus.in_valid && bus.in_ready;
  assign done = acc && sel_q == 2'd3;
  always_comb begin
    lane_d = lane_q;
    if (acc && sel_q != 2'd3) lane_d[sel_q] = bus.in_data;
    sel_d = bus.align ? 2'd0 : acc ? sel_q + 2'd1 : sel_q;
    out_d = done ? {bus.in_data, lane_q} : out_q;
    ov_d = done || (ov_q && !bus.out_ready);
  end
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sel_q <= '0;
      lane_q <= '0;
      out_q <= '0;
      ov_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      lane_q <= lane_d;
      out_q <= out_d;
      ov_q <= ov_d;
    end
  end
  assign bus.out_data = out_q;
  assign bus.out_valid = ov_q;
  assign bus.lane_sel = sel_q;
endmodule

// File: tb/tb_hardcopyii_deser14.sv
// tb_hardcopyii_deser14: directed table-driven bench for hardcopyii_deser14 with WIDTH=8
module tb_hardcopyii_deser14;
  logic clk = 1'b0;
  logic aclr = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  hardcopyii_deser14_if #(.WIDTH(8)) bus();
  hardcopyii_deser14 #(.WIDTH(8)) dut (.clk(clk), .aclr(aclr), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        al;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_sel;
  } vec_t;
  vec_t vecs[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic add(input logic v, input logic [7:0] d, input logic al, input logic ordy,
                     input logic rdy, input logic ov, input logic [31:0] od, input logic [1:0] sel);
    vecs.push_back('{v, d, al, ordy, rdy, ov, od, sel});
  endtask
  task automatic check_all(input string tag, input logic rdy, input logic ov, input logic [31:0] od, input logic [1:0] sel);
    check({tag, " in_ready"}, {31'd0, bus.in_ready}, {31'd0, rdy});
    check({tag, " out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    check({tag, " out_data"}, bus.out_data, od);
    check({tag, " lane_sel"}, {30'd0, bus.lane_sel}, {30'd0, sel});
  endtask
  task automatic drive(input logic v, input logic [7:0] d, input logic al, input logic ordy);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data = d;
    bus.align = al;
    bus.out_ready = ordy;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.align = 1'b0;
    bus.out_ready = 1'b0;
    // basic assembly then streaming
    add(1, 8'h11, 0, 1, 1, 0, 32'h0, 0);
    add(1, 8'h22, 0, 1, 1, 0, 32'h0, 1);
    add(1, 8'h33, 0, 1, 1, 0, 32'h0, 2);
    add(1, 8'h44, 0, 1, 1, 0, 32'h0, 3);
    add(1, 8'h01, 0, 1, 1, 1, 32'h44332211, 0);
    add(1, 8'h02, 0, 1, 1, 0, 32'h44332211, 1);
    add(1, 8'h03, 0, 1, 1, 0, 32'h44332211, 2);
    add(1, 8'h04, 0, 1, 1, 0, 32'h44332211, 3);
    add(1, 8'h05, 0, 1, 1, 1, 32'h04030201, 0);
    add(1, 8'h06, 0, 1, 1, 0, 32'h04030201, 1);
    add(1, 8'h07, 0, 1, 1, 0, 32'h04030201, 2);
    add(1, 8'h08, 0, 1, 1, 0, 32'h04030201, 3);
    add(1, 8'h09, 0, 1, 1, 1, 32'h08070605, 0);
    add(1, 8'h0A, 0, 1, 1, 0, 32'h08070605, 1);
    add(1, 8'h0B, 0, 1, 1, 0, 32'h08070605, 2);
    add(1, 8'h0C, 0, 1, 1, 0, 32'h08070605, 3);
    // backpressure: word held, three beats accepted, completing beat stalls
    add(0, 8'h00, 0, 0, 1, 1, 32'h0C0B0A09, 0);
    add(1, 8'hA0, 0, 0, 1, 1, 32'h0C0B0A09, 0);
    add(1, 8'hA1, 0, 0, 1, 1, 32'h0C0B0A09, 1);
    add(1, 8'hA2, 0, 0, 1, 1, 32'h0C0B0A09, 2);
    add(1, 8'hA3, 0, 0, 0, 1, 32'h0C0B0A09, 3);
    add(1, 8'hA3, 0, 0, 0, 1, 32'h0C0B0A09, 3);
    add(1, 8'hA3, 0, 1, 1, 1, 32'h0C0B0A09, 3);
    add(0, 8'h00, 0, 0, 1, 1, 32'hA3A2A1A0, 0);
    add(0, 8'h00, 0, 1, 1, 1, 32'hA3A2A1A0, 0);
    // align discards the partial word 55,66
    add(1, 8'h55, 0, 1, 1, 0, 32'hA3A2A1A0, 0);
    add(1, 8'h66, 0, 1, 1, 0, 32'hA3A2A1A0, 1);
    add(1, 8'h77, 1, 1, 0, 0, 32'hA3A2A1A0, 2);
    add(1, 8'h01, 0, 1, 1, 0, 32'hA3A2A1A0, 0);
    add(1, 8'h02, 0, 1, 1, 0, 32'hA3A2A1A0, 1);
    add(1, 8'h03, 0, 1, 1, 0, 32'hA3A2A1A0, 2);
    add(1, 8'h04, 0, 1, 1, 0, 32'hA3A2A1A0, 3);
    add(0, 8'h00, 0, 1, 1, 1, 32'h04030201, 0);
    // gapped input
    add(1, 8'hDE, 0, 1, 1, 0, 32'h04030201, 0);
    add(0, 8'h99, 0, 1, 1, 0, 32'h04030201, 1);
    add(1, 8'hAD, 0, 1, 1, 0, 32'h04030201, 1);
    add(0, 8'h99, 0, 1, 1, 0, 32'h04030201, 2);
    add(1, 8'hBE, 0, 1, 1, 0, 32'h04030201, 2);
    add(0, 8'h99, 0, 1, 1, 0, 32'h04030201, 3);
    add(1, 8'hEF, 0, 1, 1, 0, 32'h04030201, 3);
    add(0, 8'h00, 0, 0, 1, 1, 32'hEFBEADDE, 0);
    // align coinciding with the completing beat: beat dropped
    add(1, 8'hF0, 0, 1, 1, 1, 32'hEFBEADDE, 0);
    add(1, 8'hF1, 0, 1, 1, 0, 32'hEFBEADDE, 1);
    add(1, 8'hF2, 0, 1, 1, 0, 32'hEFBEADDE, 2);
    add(1, 8'hF3, 1, 1, 0, 0, 32'hEFBEADDE, 3);
    add(0, 8'h00, 0, 1, 1, 0, 32'hEFBEADDE, 0);
    #1;
    check_all("reset", 0, 0, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    aclr = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].al, vecs[i].ordy);
      #1;
      check_all($sformatf("row%0d", i), vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_sel);
    end
    // asynchronous reset with a held word and a partial word
    drive(1, 8'h11, 0, 0);
    drive(1, 8'h22, 0, 0);
    drive(1, 8'h33, 0, 0);
    drive(1, 8'h44, 0, 0);
    drive(1, 8'h55, 0, 0);
    drive(1, 8'h66, 0, 0);
    drive(0, 8'h00, 0, 0);
    #1;
    check_all("pre_aclr", 1, 1, 32'h44332211, 2);
    #2;
    aclr = 1'b1;
    #1;
    check_all("aclr_now", 0, 0, 32'h0, 0);
    drive(1, 8'h77, 0, 1);
    #1;
    check_all("aclr_held", 0, 0, 32'h0, 0);
    @(negedge clk);
    aclr = 1'b0;
    #1;
    check_all("aclr_rel", 1, 0, 32'h0, 0);
    @(negedge clk);
    #1;
    check_all("aclr_take", 1, 0, 32'h0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
